// File: rtl/ifetch_pkg.sv
// ============================================================================
// Module : ifetch_pkg
// Brief  : Shared types and constants for the instruction prefetch buffer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ifetch_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int IFQ_ENTRY    = 2 * XLEN_DEFAULT;

    // Low address bits forced to zero on a redirect target
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

    function automatic int ifq_entry_w(input int xlen);
        return 2 * xlen;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ifetch_buffer_sync_fifo.sv
// ============================================================================
// Module : sync_fifo
// Brief  : Single-clock FIFO with synchronous clear and occupancy count.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clr,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    // A push into a full FIFO is accepted only when the head leaves this cycle
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push)
            r_mem[r_wr_ptr] <= i_data;
    end

endmodule

`default_nettype wire

// File: rtl/ifetch_buffer.sv
// ============================================================================
// Module : ifetch_buffer
// Brief  : Sequential instruction prefetcher with credit-limited issue,
//          in-order response buffering and redirect flush.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifetch_buffer
    import ifetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_addr_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_addr_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i
);

    localparam int              CW      = $clog2(DEPTH) + 1;
    localparam int              EW      = ifq_entry_w(XLEN);
    localparam logic [CW:0]     c_depth = (CW+1)'(DEPTH);
    localparam logic [XLEN-1:0] c_align = ~XLEN'(ALIGN_MASK);

    fetch_state_t    r_state;
    logic [XLEN-1:0] r_fetch_addr;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_discard;

    logic [CW-1:0]   w_out_next;
    logic [CW-1:0]   w_discard_next;
    logic            w_grant;
    logic            w_draining;
    logic            w_deliver;
    logic            w_pop;
    logic [EW-1:0]   w_ifq_head;
    logic            w_ifq_full;
    logic            w_ifq_empty;
    logic [CW-1:0]   w_ifq_count;
    logic [XLEN-1:0] w_tag_head;
    logic            w_tag_full;
    logic            w_tag_empty;
    logic [CW-1:0]   w_tag_count;

    // Credit: buffered plus in-flight words never exceed the FIFO depth
    assign mem_req_o  = !rst && !redirect_i &&
                        (({1'b0, w_ifq_count} + {1'b0, r_outstanding}) < c_depth);
    assign mem_addr_o = r_fetch_addr;
    assign w_grant    = mem_req_o && mem_gnt_i;
    assign w_draining = (r_state == DRAIN);
    assign w_out_next = r_outstanding + CW'(w_grant) - CW'(mem_rvalid_i);
    assign w_deliver  = mem_rvalid_i && !w_draining && !redirect_i;
    assign w_pop      = instr_valid_o && instr_ready_i && !redirect_i;

    assign instr_valid_o = !w_ifq_empty;
    assign instr_o       = instr_valid_o ? w_ifq_head[EW-1:XLEN] : '0;
    assign instr_pc_o    = instr_valid_o ? w_ifq_head[XLEN-1:0]  : '0;

    always_comb begin
        w_discard_next = r_discard;
        if (redirect_i)
            w_discard_next = w_out_next;
        else if (mem_rvalid_i && w_draining)
            w_discard_next = r_discard - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= RUN;
            r_fetch_addr  <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_outstanding <= w_out_next;
            r_discard     <= w_discard_next;
            r_state       <= (w_discard_next != '0) ? DRAIN : RUN;
            if (redirect_i)
                r_fetch_addr <= redirect_addr_i & c_align;
            else if (w_grant)
                r_fetch_addr <= r_fetch_addr + XLEN'(4);
        end
    end

    // Tags survive a redirect: stale responses still pop their own PC
    sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_q (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (1'b0),
        .i_push  (w_grant),
        .i_data  (r_fetch_addr),
        .i_pop   (mem_rvalid_i),
        .o_data  (w_tag_head),
        .o_full  (w_tag_full),
        .o_empty (w_tag_empty),
        .o_count (w_tag_count)
    );

    sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_instr_q (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (redirect_i),
        .i_push  (w_deliver),
        .i_data  ({mem_rdata_i, w_tag_head}),
        .i_pop   (w_pop),
        .o_data  (w_ifq_head),
        .o_full  (w_ifq_full),
        .o_empty (w_ifq_empty),
        .o_count (w_ifq_count)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(mem_rvalid_i && !w_draining && w_ifq_full));
    a_rsp_has_tag: assert property (@(posedge clk) disable iff (rst)
        !(mem_rvalid_i && w_tag_empty));
    a_tag_room:    assert property (@(posedge clk) disable iff (rst)
        !(w_grant && w_tag_full));
    a_tag_track:   assert property (@(posedge clk) disable iff (rst)
        w_tag_count == r_outstanding);

endmodule

`default_nettype wire

// File: tb/tb_ifetch_buffer.sv
// ============================================================================
// Module : tb_ifetch_buffer
// Brief  : Directed self-checking bench for ifetch_buffer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ifetch_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_addr_i = '0;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int lat = 1;
    int n_grants = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } rsp_t;
    rsp_t q[$];

    ifetch_buffer #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_i      (redirect_i),
        .redirect_addr_i (redirect_addr_i),
        .instr_o         (instr_o),
        .instr_pc_o      (instr_pc_o),
        .instr_valid_o   (instr_valid_o),
        .instr_ready_i   (instr_ready_i),
        .mem_req_o       (mem_req_o),
        .mem_addr_o      (mem_addr_o),
        .mem_gnt_i       (mem_gnt_i),
        .mem_rvalid_i    (mem_rvalid_i),
        .mem_rdata_i     (mem_rdata_i)
    );

    always #5 clk = ~clk;

    // One clock cycle: sample this cycle's grant, then play the memory model
    // (in-order responses, rdata = addr + 0x1000_0000, fixed latency `lat`).
    task automatic tick();
        logic        g;
        logic        r;
        logic [31:0] a;
        #1;
        g = mem_req_o && mem_gnt_i;
        a = mem_addr_o;
        r = rst;
        @(posedge clk);
        #1;
        cyc++;
        if (r) begin
            q.delete();
        end else if (g) begin
            q.push_back('{a, cyc - 1 + lat});
            n_grants++;
        end
        if (q.size() > 0 && q[0].due <= cyc) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = q[0].addr + 32'h1000_0000;
            void'(q.pop_front());
        end else begin
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = '0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_i = 1'b0;
        mem_gnt_i = 1'b0;
        instr_ready_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        n_grants = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        #1;
        n_chk++; if (instr_valid_o !== 1'b0) $display("FAIL reset_valid: got %b exp 0", instr_valid_o); else n_pass++;
        n_chk++; if (instr_o !== 32'h0) $display("FAIL reset_instr: got %h exp 0", instr_o); else n_pass++;
        n_chk++; if (instr_pc_o !== 32'h0) $display("FAIL reset_pc: got %h exp 0", instr_pc_o); else n_pass++;
        n_chk++; if (mem_req_o !== 1'b0) $display("FAIL reset_req: got %b exp 0", mem_req_o); else n_pass++;
        n_chk++; if (mem_addr_o !== 32'h0) $display("FAIL reset_addr: got %h exp 0", mem_addr_o); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_stream();
        do_reset();
        lat = 1; mem_gnt_i = 1'b1; instr_ready_i = 1'b1;
        #1;
        n_chk++; if (mem_req_o !== 1'b1) $display("FAIL stream_req0: got %b exp 1", mem_req_o); else n_pass++;
        n_chk++; if (mem_addr_o !== 32'h0) $display("FAIL stream_addr0: got %h exp 0", mem_addr_o); else n_pass++;
        tick();
        n_chk++; if (instr_valid_o !== 1'b0) $display("FAIL stream_nocomb: got %b exp 0", instr_valid_o); else n_pass++;
        n_chk++; if (mem_addr_o !== 32'h4) $display("FAIL stream_addr1: got %h exp 4", mem_addr_o); else n_pass++;
        tick();
        n_chk++; if (instr_valid_o !== 1'b1) $display("FAIL stream_valid: got %b exp 1", instr_valid_o); else n_pass++;
        n_chk++; if (instr_pc_o !== 32'h0) $display("FAIL stream_pc0: got %h exp 0", instr_pc_o); else n_pass++;
        n_chk++; if (instr_o !== 32'h1000_0000) $display("FAIL stream_instr0: got %h exp 10000000", instr_o); else n_pass++;
        n_chk++; if (mem_addr_o !== 32'h8) $display("FAIL stream_addr2: got %h exp 8", mem_addr_o); else n_pass++;
        tick();
        n_chk++; if (instr_pc_o !== 32'h4) $display("FAIL stream_pc1: got %h exp 4", instr_pc_o); else n_pass++;
        n_chk++; if (instr_o !== 32'h1000_0004) $display("FAIL stream_instr1: got %h exp 10000004", instr_o); else n_pass++;
    endtask

    task automatic test_full();
        do_reset();
        lat = 1; mem_gnt_i = 1'b1; instr_ready_i = 1'b0;
        repeat (6) tick();
        #1;
        n_chk++; if (n_grants !== 4) $display("FAIL full_grants: got %0d exp 4", n_grants); else n_pass++;
        n_chk++; if (mem_req_o !== 1'b0) $display("FAIL full_req: got %b exp 0", mem_req_o); else n_pass++;
        n_chk++; if (mem_addr_o !== 32'h10) $display("FAIL full_addr: got %h exp 10", mem_addr_o); else n_pass++;
        n_chk++; if (instr_pc_o !== 32'h0) $display("FAIL full_head: got %h exp 0", instr_pc_o); else n_pass++;
        instr_ready_i = 1'b1;
        tick();
        #1;
        n_chk++; if (mem_req_o !== 1'b1) $display("FAIL full_req_again: got %b exp 1", mem_req_o); else n_pass++;
        n_chk++; if (mem_addr_o !== 32'h10) $display("FAIL full_addr_again: got %h exp 10", mem_addr_o); else n_pass++;
        n_chk++; if (instr_pc_o !== 32'h4) $display("FAIL full_next_head: got %h exp 4", instr_pc_o); else n_pass++;
    endtask

    task automatic test_redirect();
        do_reset();
        lat = 3; mem_gnt_i = 1'b1; instr_ready_i = 1'b1;
        tick();
        tick();
        redirect_i = 1'b1; redirect_addr_i = 32'h103;
        #1;
        n_chk++; if (mem_req_o !== 1'b0) $display("FAIL redir_req: got %b exp 0", mem_req_o); else n_pass++;
        tick();
        redirect_i = 1'b0;
        #1;
        n_chk++; if (mem_addr_o !== 32'h100) $display("FAIL redir_addr: got %h exp 100", mem_addr_o); else n_pass++;
        for (int k = 0; k < 12 && instr_valid_o !== 1'b1; k++) tick();
        n_chk++; if (instr_valid_o !== 1'b1) $display("FAIL redir_timeout: got %b exp 1", instr_valid_o); else n_pass++;
        n_chk++; if (instr_pc_o !== 32'h100) $display("FAIL redir_first_pc: got %h exp 100", instr_pc_o); else n_pass++;
        n_chk++; if (instr_o !== 32'h1000_0100) $display("FAIL redir_first_instr: got %h exp 10000100", instr_o); else n_pass++;
    endtask

    task automatic test_redirect_collide();
        do_reset();
        lat = 2; mem_gnt_i = 1'b1; instr_ready_i = 1'b1;
        tick();
        tick();
        tick();
        #1;
        n_chk++; if (instr_pc_o !== 32'h0) $display("FAIL coll_pre_head: got %h exp 0", instr_pc_o); else n_pass++;
        redirect_i = 1'b1; redirect_addr_i = 32'h200;
        tick();
        redirect_i = 1'b0;
        #1;
        n_chk++; if (instr_valid_o !== 1'b0) $display("FAIL coll_flushed: got %b exp 0", instr_valid_o); else n_pass++;
        n_chk++; if (mem_addr_o !== 32'h200) $display("FAIL coll_addr: got %h exp 200", mem_addr_o); else n_pass++;
        for (int k = 0; k < 12 && instr_valid_o !== 1'b1; k++) tick();
        n_chk++; if (instr_pc_o !== 32'h200) $display("FAIL coll_first_pc: got %h exp 200", instr_pc_o); else n_pass++;
        n_chk++; if (instr_o !== 32'h1000_0200) $display("FAIL coll_first_instr: got %h exp 10000200", instr_o); else n_pass++;
    endtask

    task automatic test_stall();
        do_reset();
        lat = 1; mem_gnt_i = 1'b0; instr_ready_i = 1'b1;
        redirect_i = 1'b1; redirect_addr_i = 32'h20;
        tick();
        redirect_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_chk++; if (mem_req_o !== 1'b1) $display("FAIL stall_req[%0d]: got %b exp 1", k, mem_req_o); else n_pass++;
            n_chk++; if (mem_addr_o !== 32'h20) $display("FAIL stall_addr[%0d]: got %h exp 20", k, mem_addr_o); else n_pass++;
            n_chk++; if (instr_valid_o !== 1'b0) $display("FAIL stall_valid[%0d]: got %b exp 0", k, instr_valid_o); else n_pass++;
            tick();
        end
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        #1;
        n_chk++; if (mem_addr_o !== 32'h24) $display("FAIL stall_addr_after: got %h exp 24", mem_addr_o); else n_pass++;
        tick();
        n_chk++; if (instr_valid_o !== 1'b1) $display("FAIL stall_valid_after: got %b exp 1", instr_valid_o); else n_pass++;
        n_chk++; if (instr_pc_o !== 32'h20) $display("FAIL stall_pc: got %h exp 20", instr_pc_o); else n_pass++;
        n_chk++; if (instr_o !== 32'h1000_0020) $display("FAIL stall_instr: got %h exp 10000020", instr_o); else n_pass++;
    endtask

    task automatic test_wrap_reset();
        do_reset();
        lat = 1; mem_gnt_i = 1'b1; instr_ready_i = 1'b1;
        redirect_i = 1'b1; redirect_addr_i = 32'hFFFF_FFFE;
        tick();
        redirect_i = 1'b0;
        #1;
        n_chk++; if (mem_addr_o !== 32'hFFFF_FFFC) $display("FAIL wrap_addr_top: got %h exp fffffffc", mem_addr_o); else n_pass++;
        tick();
        n_chk++; if (mem_addr_o !== 32'h0) $display("FAIL wrap_addr_zero: got %h exp 0", mem_addr_o); else n_pass++;
        tick();
        n_chk++; if (instr_pc_o !== 32'hFFFF_FFFC) $display("FAIL wrap_pc: got %h exp fffffffc", instr_pc_o); else n_pass++;
        n_chk++; if (instr_o !== 32'h0FFF_FFFC) $display("FAIL wrap_instr: got %h exp 0ffffffc", instr_o); else n_pass++;
        rst = 1'b1;
        #1;
        n_chk++; if (mem_req_o !== 1'b0) $display("FAIL midrst_req_now: got %b exp 0", mem_req_o); else n_pass++;
        tick();
        n_chk++; if (instr_valid_o !== 1'b0) $display("FAIL midrst_valid: got %b exp 0", instr_valid_o); else n_pass++;
        n_chk++; if (instr_o !== 32'h0) $display("FAIL midrst_instr: got %h exp 0", instr_o); else n_pass++;
        n_chk++; if (instr_pc_o !== 32'h0) $display("FAIL midrst_pc: got %h exp 0", instr_pc_o); else n_pass++;
        n_chk++; if (mem_addr_o !== 32'h0) $display("FAIL midrst_addr: got %h exp 0", mem_addr_o); else n_pass++;
        rst = 1'b0; mem_gnt_i = 1'b0; instr_ready_i = 1'b0;
        tick();
        n_chk++; if (instr_valid_o !== 1'b0) $display("FAIL postrst_valid: got %b exp 0", instr_valid_o); else n_pass++;
        n_chk++; if (mem_req_o !== 1'b1) $display("FAIL postrst_req: got %b exp 1", mem_req_o); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_redirect();
        test_redirect_collide();
        test_stall();
        test_wrap_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule

`default_nettype wire
